banco_registros_mp: RTL
=======================

BANCO_REGISTROS_MP -- requirements
Module: banco_registros_mp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bits per register.
REQ-002 SHALL have parameter REGFILE_WIDTH, default 5, address bits; NREGS = 2**REGFILE_WIDTH.
REQ-003 SHALL have parameter NUM_RD, default 2, read ports (legal 1..4).
REQ-004 SHALL have parameter NUM_WR, default 1, write ports (legal 1..2).
REQ-005 SHALL have the following ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- we  in  NUM_WR  per-port write enable.
- addressW  in  NUM_WR*REGFILE_WIDTH  write addresses, port k at [k*RW +: RW].
- data  in  NUM_WR*DATA_WIDTH  write data, same packing.
- addressR  in  NUM_RD*REGFILE_WIDTH  read addresses.
- regR  out  NUM_RD*DATA_WIDTH  read data.
- rdy  out  NUM_RD  register at addressR[j] not pending.
- issue  in  1  mark a destination pending.
- issueAddr  in  REGFILE_WIDTH  destination to mark.
- registers  out  NREGS*DATA_WIDTH  debug dump, register 0 in MSBs, NREGS-1 in LSBs.

Function
REQ-006 Read ports SHALL be combinational from addressR; no read latency.
REQ-007 Register 0 SHALL read 0 always; writes to address 0 SHALL be ignored.
REQ-008 Write SHALL take effect at posedge clk when we[k]=1 and reset=0; visible in the stored array from the next cycle.
REQ-009 Two write ports to the same nonzero address in the same cycle SHALL store the higher-index port's data.
REQ-010 Scoreboard: one pending bit per register; issue=1 SHALL set pending[issueAddr] at posedge, except address 0.
REQ-011 A write (we[k]=1) SHALL clear pending[addressW[k]] at posedge.
REQ-012 issue and write to the same address in one cycle SHALL leave pending set (issue wins).
REQ-013 rdy[j] SHALL equal ~pending[addressR[j]]; rdy for address 0 SHALL be 1.
REQ-014 registers SHALL reflect stored array only (no bypass), register 0 field constant 0.

Reset
REQ-015 reset=1 SHALL asynchronously clear all registers and all pending bits; regR=0 for every port, rdy all 1.
REQ-016 While reset=1, writes and issue SHALL be ignored; reads SHALL return 0.
REQ-017 Reset deasserting mid-operation SHALL resume with a clean array; no queued writes replayed.

Configuration
REQ-018 With macro BANCO_REGISTROS_BYPASS_EN defined: when we[k]=1 and addressW[k]=addressR[j]!=0, regR[j] SHALL return data[k] same cycle (higher k wins) and rdy[j] SHALL be 1.
REQ-019 Without BANCO_REGISTROS_BYPASS_EN: regR returns stored value only; rdy reflects pending before the write clears it.

Structure
REQ-020 Shared package banco_registros_pkg SHALL hold default DATA_WIDTH, REGFILE_WIDTH, NUM_RD, NUM_WR and the zero-register address constant.
REQ-021 Scoreboard SHALL be a sub-module banco_scoreboard (set/clear/lookup of pending bits); array and bypass stay in the top.

Verification
REQ-022 Reset: write 0xDEADBEEF to r5, assert reset between clock edges -> regR of r5 reads 0 immediately, rdy all 1.
REQ-023 r0: we=1, addressW=0, data=0x1234 -> regR(addressR=0)=0, registers MSB field 0.
REQ-024 Dual write: port0 r7=0x11, port1 r7=0x22 same cycle -> r7 reads 0x22 next cycle.
REQ-025 Scoreboard: issue r9, next cycle rdy(r9)=0; write r9=0x55 -> rdy=1 after edge; issue+write r9 same cycle -> rdy stays 0.
REQ-026 Bypass: write r3=0xA5A5A5A5 while addressR=3 -> with BANCO_REGISTROS_BYPASS_EN regR=0xA5A5A5A5 same cycle; without, old value until next cycle.
REQ-027 Dump: write r1=1, r31=0x1F -> registers[(NREGS-2)*32 +: 32]=1, registers[31:0]=0x1F.

Source files
------------

// File: rtl/banco_registros_pkg.sv
// Shared defaults for the multi-port register file and its scoreboard.
//   DefDataWidth    : bits per register
//   DefRegfileWidth : address bits (NREGS = 2**width)
//   DefNumRd/Wr     : default read/write port counts
//   ZeroRegAddr     : hard-wired zero register address
package banco_registros_pkg;

  localparam int unsigned DefDataWidth    = 32;
  localparam int unsigned DefRegfileWidth = 5;
  localparam int unsigned DefNumRd        = 2;
  localparam int unsigned DefNumWr        = 1;
  localparam int unsigned ZeroRegAddr     = 0;

endpackage

// File: rtl/banco_scoreboard.sv
// Pending-bit scoreboard: one bit per register.
//   clk, reset   : clock, asynchronous active-high reset (clears all pending bits)
//   we_i         : per-write-port enable; a write clears pending for its address
//   addr_w_i     : packed write addresses
//   issue_i      : set pending for issue_addr_i (ignored for the zero register)
//   issue_addr_i : destination to mark pending
//   addr_r_i     : packed read addresses
//   pending_o    : pending bit looked up for each read port
module banco_scoreboard
  import banco_registros_pkg::*;
#(
  parameter int unsigned REGFILE_WIDTH = DefRegfileWidth,
  parameter int unsigned NUM_RD        = DefNumRd,
  parameter int unsigned NUM_WR        = DefNumWr
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_WR-1:0]               we_i,
  input  logic [NUM_WR*REGFILE_WIDTH-1:0] addr_w_i,
  input  logic                            issue_i,
  input  logic [REGFILE_WIDTH-1:0]        issue_addr_i,
  input  logic [NUM_RD*REGFILE_WIDTH-1:0] addr_r_i,
  output logic [NUM_RD-1:0]               pending_o
);

  localparam int unsigned NRegs = 2 ** REGFILE_WIDTH;
  localparam logic [REGFILE_WIDTH-1:0] ZeroAddr = REGFILE_WIDTH'(ZeroRegAddr);

  logic [NRegs-1:0] pending_q, pending_d;

  // Clears are applied before the set so that issue wins over a same-cycle write.
  always_comb begin
    pending_d = pending_q;
    for (int k = 0; k < NUM_WR; k++) begin
      if (we_i[k]) begin
        pending_d[addr_w_i[k*REGFILE_WIDTH +: REGFILE_WIDTH]] = 1'b0;
      end
    end
    if (issue_i) begin
      pending_d[issue_addr_i] = 1'b1;
    end
    pending_d[ZeroAddr] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_RD; j++) begin
      pending_o[j] = pending_q[addr_r_i[j*REGFILE_WIDTH +: REGFILE_WIDTH]];
    end
  end

endmodule

// File: rtl/banco_registros_mp.sv
// Multi-port register file with zero register and pending-bit scoreboard.
//   clk, reset : clock, asynchronous active-high reset (clears array and scoreboard)
//   we         : per-port write enable
//   addressW   : write addresses, port k at [k*RW +: RW]
//   data       : write data, port k at [k*DW +: DW]
//   addressR   : read addresses, combinational reads
//   regR       : read data per read port
//   rdy        : register at addressR[j] not pending
//   issue      : mark issueAddr pending
//   issueAddr  : destination to mark
//   registers  : debug dump, register 0 in MSBs, NREGS-1 in LSBs (stored values only)
// Optional feature: define BANCO_REGISTROS_BYPASS_EN to forward same-cycle write data
// (and report ready) on read ports whose address matches an active write.
module banco_registros_mp
  import banco_registros_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DefDataWidth,
  parameter int unsigned REGFILE_WIDTH = DefRegfileWidth,
  parameter int unsigned NUM_RD        = DefNumRd,
  parameter int unsigned NUM_WR        = DefNumWr,
  parameter int unsigned NREGS         = 2 ** REGFILE_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_WR-1:0]               we,
  input  logic [NUM_WR*REGFILE_WIDTH-1:0] addressW,
  input  logic [NUM_WR*DATA_WIDTH-1:0]    data,
  input  logic [NUM_RD*REGFILE_WIDTH-1:0] addressR,
  output logic [NUM_RD*DATA_WIDTH-1:0]    regR,
  output logic [NUM_RD-1:0]               rdy,
  input  logic                            issue,
  input  logic [REGFILE_WIDTH-1:0]        issueAddr,
  output logic [NREGS*DATA_WIDTH-1:0]     registers
);

  localparam logic [REGFILE_WIDTH-1:0] ZeroAddr = REGFILE_WIDTH'(ZeroRegAddr);

  logic [DATA_WIDTH-1:0] regs_q [NREGS];
  logic [DATA_WIDTH-1:0] regs_d [NREGS];
  logic [NUM_RD-1:0]     pending_rd;

  banco_scoreboard #(
    .REGFILE_WIDTH(REGFILE_WIDTH),
    .NUM_RD       (NUM_RD),
    .NUM_WR       (NUM_WR)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .we_i        (we),
    .addr_w_i    (addressW),
    .issue_i     (issue),
    .issue_addr_i(issueAddr),
    .addr_r_i    (addressR),
    .pending_o   (pending_rd)
  );

  // Ascending port order: the highest-index port writing an address wins.
  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NUM_WR; k++) begin
      if (we[k] && (addressW[k*REGFILE_WIDTH +: REGFILE_WIDTH] != ZeroAddr)) begin
        regs_d[addressW[k*REGFILE_WIDTH +: REGFILE_WIDTH]] = data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    logic [REGFILE_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0]    rval;
    logic                     rrdy;
    raddr = '0;
    rval  = '0;
    rrdy  = 1'b1;
    regR  = '0;
    rdy   = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      raddr = addressR[j*REGFILE_WIDTH +: REGFILE_WIDTH];
      // Register 0 is never written, so the stored read already returns zero.
      rval  = regs_q[raddr];
      rrdy  = ~pending_rd[j] | (raddr == ZeroAddr);
`ifdef BANCO_REGISTROS_BYPASS_EN
      // Forwarding is suppressed during reset so reads stay zero.
      if (!reset) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (we[k] && (raddr != ZeroAddr) &&
              (addressW[k*REGFILE_WIDTH +: REGFILE_WIDTH] == raddr)) begin
            rval = data[k*DATA_WIDTH +: DATA_WIDTH];
            rrdy = 1'b1;
          end
        end
      end
`endif
      regR[j*DATA_WIDTH +: DATA_WIDTH] = rval;
      rdy[j] = rrdy;
    end
  end

  always_comb begin
    registers = '0;
    for (int i = 1; i < NREGS; i++) begin
      registers[(NREGS-1-i)*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

endmodule
